memcoll_stream_ctrl: RTL and testbench

- Upstream sequencer for mem_collection: `collection` collections, each of `z` single-port, read-first memories of `depth` cells.
- Accepts a valid/ready stream of `depth` beats. Each beat is one word per memory. The block writes the beats into the memories with skewed (interleaved) addressing.
- After the fill, it drains the same `depth` beats back out in order, aligned to the memories' 1-cycle registered read.
- Feeds the mem_collection address/we/data_in ports and consumes its data_out.

---
 rtl/memcoll_stream_ctrl.sv | 138 +++++++++++++
 tb/tb_memcoll_stream_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memcoll_stream_ctrl.sv
// Purpose : fills a mem_collection with a stream of depth beats (skewed addressing), then drains them back in order.
// Latency : first drained beat 1 cycle after the last fill beat is accepted; a stall-free pass is 2*depth+2 cycles from start.
// Backpr. : in_ready_o is high for the whole fill and stalls are unlimited; the drain has no backpressure.
//
// Ports:
//   clk_i, reset_i (async, active-low)     clock / reset
//   start_i                                starts a pass, sampled only while idle
//   in_valid_i / in_ready_o / in_data_i    fill stream, one word per memory per beat
//   address_o / we_o / data_in_o           to the memories
//   data_out_i                             registered read data from the memories
//   out_valid_o / out_data_o               drained beats
//   busy_o / done_o                        pass in progress / one-cycle end-of-pass pulse
module memcoll_stream_ctrl #(
   parameter  int collection = 2,
   parameter  int z          = 2,
   parameter  int depth      = 2,
   parameter  int width      = 4,
   localparam int addrsize   = (depth == 1) ? 1 : $clog2(depth)
) (
   input  logic                                         clk_i,
   input  logic                                         reset_i,
   input  logic                                         start_i,
   input  logic                                         in_valid_i,
   output logic                                         in_ready_o,
   input  logic [collection-1:0][z-1:0][width-1:0]      in_data_i,
   output logic [collection-1:0][z-1:0][addrsize-1:0]   address_o,
   output logic [collection-1:0][z-1:0]                 we_o,
   output logic [collection-1:0][z-1:0][width-1:0]      data_in_o,
   input  logic [collection-1:0][z-1:0][width-1:0]      data_out_i,
   output logic                                         out_valid_o,
   output logic [collection-1:0][z-1:0][width-1:0]      out_data_o,
   output logic                                         busy_o,
   output logic                                         done_o
);

   localparam int                AW1     = addrsize + 1;
   localparam logic [addrsize-1:0] CNT_LAST = addrsize'(depth - 1);
   localparam logic [AW1-1:0]    DEPTH_W = AW1'(depth);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [addrsize-1:0] cnt_q, cnt_d;
   logic                ov_q, ov_d;
   logic [addrsize-1:0] skew_base;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      in_ready_o = 1'b0;
      we_o       = '0;
      data_in_o  = '0;
      done_o     = 1'b0;
      busy_o     = (state_q != S_IDLE);
      // A read is issued in every DRAIN cycle, so the flag is simply "were we draining".
      ov_d       = (state_q == S_DRAIN);
      // Idle and done present the unskewed base address.
      skew_base  = '0;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_FILL;
               cnt_d   = '0;
            end
         end
         S_FILL: begin
            in_ready_o = 1'b1;
            skew_base  = cnt_q;
            if (in_valid_i) begin
               we_o      = '1;
               data_in_o = in_data_i;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DRAIN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + addrsize'(1);
               end
            end
         end
         S_DRAIN: begin
            skew_base = cnt_q;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + addrsize'(1);
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Memory j is offset by j cells so beat k element j lives at (k+j) mod depth.
   // The sum is one bit wider and reduced by a single subtract, which is exact
   // because both operands are already below depth.
   for (genvar gi = 0; gi < collection; gi++) begin : g_col
      for (genvar gj = 0; gj < z; gj++) begin : g_mem
         localparam logic [AW1-1:0] JSKEW = AW1'(gj % depth);
         logic [AW1-1:0] sum;
         always_comb begin
            sum = {1'b0, skew_base} + JSKEW;
            if (sum >= DEPTH_W) begin
               sum = sum - DEPTH_W;
            end
         end
         // Forced to zero while reset is held so every output is quiet during reset.
         assign address_o[gi][gj] = reset_i ? sum[addrsize-1:0] : '0;
      end
   end

   assign out_valid_o = ov_q;
   assign out_data_o  = ov_q ? data_out_i : '0;

endmodule

// File: tb/tb_memcoll_stream_ctrl.sv
module tb_memcoll_stream_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- instance A: defaults (2,2,2,4) ----------------
   typedef logic [1:0][1:0][3:0] beat_a_t;
   logic          start_a = 0, vld_a = 0, rdy_a, ov_a, busy_a, done_a;
   beat_a_t       ind_a = '0, wdat_a, rdat_a, od_a;
   logic [1:0][1:0][0:0] addr_a;
   logic [1:0][1:0]      we_a;
   logic [3:0] mem_a [2][2][2];

   memcoll_stream_ctrl u_a (
      .clk_i(clk), .reset_i(rst_n), .start_i(start_a), .in_valid_i(vld_a), .in_ready_o(rdy_a),
      .in_data_i(ind_a), .address_o(addr_a), .we_o(we_a), .data_in_o(wdat_a), .data_out_i(rdat_a),
      .out_valid_o(ov_a), .out_data_o(od_a), .busy_o(busy_a), .done_o(done_a));

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            rdat_a[i][j] <= mem_a[i][j][addr_a[i][j]];
            if (we_a[i][j]) mem_a[i][j][addr_a[i][j]] <= wdat_a[i][j];
         end
   end

   function automatic beat_a_t mk_a(input int base);
      beat_a_t r;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            r[i][j] = 4'(i + j + base);
      return r;
   endfunction

   // ---------------- instance B: collection=1, z=3, depth=3, width=8 ----------------
   typedef logic [0:0][2:0][7:0] beat_b_t;
   logic          start_b = 0, vld_b = 0, rdy_b, ov_b, busy_b, done_b;
   beat_b_t       ind_b = '0, wdat_b, rdat_b, od_b;
   logic [0:0][2:0][1:0] addr_b;
   logic [0:0][2:0]      we_b;
   logic [7:0] mem_b [3][3];

   memcoll_stream_ctrl #(.collection(1), .z(3), .depth(3), .width(8)) u_b (
      .clk_i(clk), .reset_i(rst_n), .start_i(start_b), .in_valid_i(vld_b), .in_ready_o(rdy_b),
      .in_data_i(ind_b), .address_o(addr_b), .we_o(we_b), .data_in_o(wdat_b), .data_out_i(rdat_b),
      .out_valid_o(ov_b), .out_data_o(od_b), .busy_o(busy_b), .done_o(done_b));

   always @(posedge clk) begin
      for (int j = 0; j < 3; j++) begin
         rdat_b[0][j] <= mem_b[j][addr_b[0][j]];
         if (we_b[0][j]) mem_b[j][addr_b[0][j]] <= wdat_b[0][j];
      end
   end

   function automatic beat_b_t mk_b(input int k);
      beat_b_t r;
      for (int j = 0; j < 3; j++) r[0][j] = 8'(10 * k + j);
      return r;
   endfunction

   // ---------------- instance C: collection=1, z=2, depth=1, width=4 ----------------
   logic          start_c = 0, vld_c = 0, rdy_c, ov_c, busy_c, done_c;
   logic [0:0][1:0][3:0] ind_c = '0, wdat_c, rdat_c, od_c;
   logic [0:0][1:0][0:0] addr_c;
   logic [0:0][1:0]      we_c;
   logic [3:0] mem_c [2][1];

   memcoll_stream_ctrl #(.collection(1), .z(2), .depth(1), .width(4)) u_c (
      .clk_i(clk), .reset_i(rst_n), .start_i(start_c), .in_valid_i(vld_c), .in_ready_o(rdy_c),
      .in_data_i(ind_c), .address_o(addr_c), .we_o(we_c), .data_in_o(wdat_c), .data_out_i(rdat_c),
      .out_valid_o(ov_c), .out_data_o(od_c), .busy_o(busy_c), .done_o(done_c));

   always @(posedge clk) begin
      for (int j = 0; j < 2; j++) begin
         rdat_c[0][j] <= mem_c[j][addr_c[0][j]];
         if (we_c[0][j]) mem_c[j][addr_c[0][j]] <= wdat_c[0][j];
      end
   end

   // One full pass on A; ends at a negedge with A back in IDLE.
   // poke holds start high through the fill and the first drain cycle.
   task automatic run_pass_a(input int b0, input int b1, input int stall, input bit poke, input string nm);
      start_a = 1'b1;
      step();
      start_a = poke;
      vld_a = 1'b1; ind_a = mk_a(b0); #1;
      check_eq({nm, "_fill0_rdy"}, 64'(rdy_a), 64'd1);
      check_eq({nm, "_fill0_we"}, 64'(we_a), 64'hF);
      check_eq({nm, "_fill0_addr"}, 64'(addr_a), 64'b1010);
      check_eq({nm, "_fill0_wdat"}, 64'(wdat_a), 64'(mk_a(b0)));
      for (int s = 0; s < stall; s++) begin
         step();
         vld_a = 1'b0; ind_a = '0; #1;
         check_eq({nm, "_stall_we"}, 64'(we_a), 64'h0);
         check_eq({nm, "_stall_addr"}, 64'(addr_a), 64'b0101);
      end
      step();
      vld_a = 1'b1; ind_a = mk_a(b1); #1;
      check_eq({nm, "_fill1_we"}, 64'(we_a), 64'hF);
      check_eq({nm, "_fill1_addr"}, 64'(addr_a), 64'b0101);
      step();
      vld_a = 1'b0; ind_a = '0; #1;
      check_eq({nm, "_drain0_ov"}, 64'(ov_a), 64'd0);
      check_eq({nm, "_drain0_rdy"}, 64'(rdy_a), 64'd0);
      check_eq({nm, "_drain0_we"}, 64'(we_a), 64'h0);
      check_eq({nm, "_drain0_wdat"}, 64'(wdat_a), 64'h0);
      check_eq({nm, "_drain0_addr"}, 64'(addr_a), 64'b1010);
      step();
      start_a = 1'b0; #1;
      check_eq({nm, "_out0_ov"}, 64'(ov_a), 64'd1);
      check_eq({nm, "_out0_dat"}, 64'(od_a), 64'(mk_a(b0)));
      check_eq({nm, "_out0_done"}, 64'(done_a), 64'd0);
      step(); #1;
      check_eq({nm, "_out1_ov"}, 64'(ov_a), 64'd1);
      check_eq({nm, "_out1_dat"}, 64'(od_a), 64'(mk_a(b1)));
      check_eq({nm, "_out1_done"}, 64'(done_a), 64'd1);
      check_eq({nm, "_out1_busy"}, 64'(busy_a), 64'd1);
      step(); #1;
      check_eq({nm, "_end_busy"}, 64'(busy_a), 64'd0);
      check_eq({nm, "_end_ov"}, 64'(ov_a), 64'd0);
      check_eq({nm, "_end_done"}, 64'(done_a), 64'd0);
      check_eq({nm, "_end_od"}, 64'(od_a), 64'h0);
   endtask

   logic [5:0] addr_exp_b [3];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1);
   end

   initial begin
      addr_exp_b = '{6'b10_01_00, 6'b00_10_01, 6'b01_00_10};

      // Reset state: everything quiet, including addresses.
      #3;
      check_eq("rst_busy", 64'(busy_a), 64'd0);
      check_eq("rst_rdy", 64'(rdy_a), 64'd0);
      check_eq("rst_ov", 64'(ov_a), 64'd0);
      check_eq("rst_addr_a", 64'(addr_a), 64'h0);
      check_eq("rst_addr_b", 64'(addr_b), 64'h0);
      check_eq("rst_we", 64'(we_a), 64'h0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; #1;
      check_eq("idle_addr_a", 64'(addr_a), 64'b1010);
      check_eq("idle_addr_b", 64'(addr_b), 64'(addr_exp_b[0]));
      check_eq("idle_done", 64'(done_a), 64'd0);

      // Basic pass, then memory placement of the skewed writes.
      run_pass_a(1, 5, 0, 1'b0, "a_basic");
      check_eq("mem_b0_m0c0", 64'(mem_a[0][0][0]), 64'd1);
      check_eq("mem_b0_m1c1", 64'(mem_a[0][1][1]), 64'd2);
      check_eq("mem_b1_m0c1", 64'(mem_a[0][0][1]), 64'd5);
      check_eq("mem_b1_c1m1c0", 64'(mem_a[1][1][0]), 64'd7);

      // Stall of 3 cycles between the beats.
      run_pass_a(1, 5, 3, 1'b0, "a_stall");
      // start held during fill/drain is ignored; overwrite with new data.
      run_pass_a(8, 11, 0, 1'b1, "a_poke");

      // Reset in the middle of the drain, right after the first output beat.
      start_a = 1'b1; step();
      start_a = 1'b0; vld_a = 1'b1; ind_a = mk_a(2); step();
      ind_a = mk_a(4); step();
      vld_a = 1'b0; ind_a = '0; step(); #1;
      check_eq("mid_ov", 64'(ov_a), 64'd1);
      check_eq("mid_od", 64'(od_a), 64'(mk_a(2)));
      rst_n = 1'b0; #1;
      check_eq("arst_ov", 64'(ov_a), 64'd0);
      check_eq("arst_od", 64'(od_a), 64'h0);
      check_eq("arst_busy", 64'(busy_a), 64'd0);
      check_eq("arst_done", 64'(done_a), 64'd0);
      check_eq("arst_addr", 64'(addr_a), 64'h0);
      check_eq("arst_we", 64'(we_a), 64'h0);
      step();
      rst_n = 1'b1; #1;
      check_eq("post_rst_busy", 64'(busy_a), 64'd0);
      check_eq("post_rst_addr", 64'(addr_a), 64'b1010);
      run_pass_a(9, 12, 0, 1'b0, "a_rerun");

      // depth=3, z=3: wrapping skew and in-order drain.
      start_b = 1'b1; step();
      start_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vld_b = 1'b1; ind_b = mk_b(k); #1;
         check_eq("b_fill_we", 64'(we_b), 64'h7);
         check_eq("b_fill_addr", 64'(addr_b), 64'(addr_exp_b[k]));
         step();
      end
      vld_b = 1'b0; ind_b = '0; #1;
      check_eq("b_drain0_ov", 64'(ov_b), 64'd0);
      check_eq("b_drain0_addr", 64'(addr_b), 64'(addr_exp_b[0]));
      step(); #1;
      check_eq("b_out0", 64'(od_b), 64'h020100);
      check_eq("b_out0_ov", 64'(ov_b), 64'd1);
      step(); #1;
      check_eq("b_out1", 64'(od_b), 64'h0C0B0A);
      check_eq("b_out1_done", 64'(done_b), 64'd0);
      step(); #1;
      check_eq("b_out2", 64'(od_b), 64'h161514);
      check_eq("b_out2_done", 64'(done_b), 64'd1);
      step(); #1;
      check_eq("b_end_busy", 64'(busy_b), 64'd0);

      // depth=1: one beat in, one beat out, address fixed at 0.
      check_eq("c_idle_addr", 64'(addr_c), 64'h0);
      start_c = 1'b1; step();
      start_c = 1'b0; vld_c = 1'b1; ind_c = 8'h65; #1;
      check_eq("c_fill_rdy", 64'(rdy_c), 64'd1);
      check_eq("c_fill_we", 64'(we_c), 64'h3);
      check_eq("c_fill_addr", 64'(addr_c), 64'h0);
      check_eq("c_fill_wdat", 64'(wdat_c), 64'h65);
      step();
      vld_c = 1'b0; ind_c = '0; #1;
      check_eq("c_drain_ov", 64'(ov_c), 64'd0);
      check_eq("c_drain_done", 64'(done_c), 64'd0);
      check_eq("c_drain_rdy", 64'(rdy_c), 64'd0);
      step(); #1;
      check_eq("c_out_ov", 64'(ov_c), 64'd1);
      check_eq("c_out_dat", 64'(od_c), 64'h65);
      check_eq("c_out_done", 64'(done_c), 64'd1);
      step(); #1;
      check_eq("c_end_busy", 64'(busy_c), 64'd0);
      check_eq("c_end_done", 64'(done_c), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
